hack_memory: RTL and testbench
==============================

# hack_memory

Data-memory responder for the Hack CPU: services the CPU's `addressM`/`writeM`/`outM` requests and returns `inM` in the same cycle. It holds 16K words of RAM, an 8K-word screen shadow memory and the keyboard register. Every screen write is forwarded to the display side through a ready/valid FIFO. It sits between the CPU and the display and keyboard controllers in the top-level computer.

## Interface

Parameters:
- `FIFO_DEPTH`, default 16: screen-update FIFO depth in entries; must be a power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `addressM`  in  16  CPU data address.
- `writeM`  in  1  CPU write enable for the current cycle.
- `outM`  in  16  CPU write data.
- `inM`  out  16  read data to the CPU; combinational from `addressM`.
- `kbd_valid`  in  1  one-cycle pulse: a new key code is on `kbd_code`.
- `kbd_code`  in  16  key code from the keyboard decoder.
- `kbd_release`  in  1  one-cycle pulse: the key was released.
- `fb_valid`  out  1  screen-update FIFO is non-empty.
- `fb_addr`  out  13  screen word offset of the head entry.
- `fb_data`  out  16  pixel word of the head entry.
- `fb_ready`  in  1  display side accepts the head entry.
- `fb_overflow`  out  1  sticky: at least one screen update was dropped.

## Operation

- Address map:
  - RAM 0x0000–0x3FFF.
  - SCREEN 0x4000–0x5FFF (offset = `addressM[12:0]`).
  - KBD 0x6000.
  - Anything else is unmapped.
- Reads (`inM`):
  - RAM and SCREEN return the stored word.
  - KBD returns the keyboard register.
  - Unmapped addresses return 0x0000.
- Writes when `writeM` = 1 at the rising edge:
  - RAM: the word updates.
  - SCREEN: the shadow word updates and `{offset, outM}` is pushed into the FIFO.
  - KBD and unmapped addresses: ignored, no side effects.
- Keyboard register:
  - `kbd_valid` loads `kbd_code`.
  - `kbd_release` clears the register to 0x0000.
  - If both arrive in the same cycle, `kbd_valid` wins.
- FIFO behaviour:
  - Head entry is popped when `fb_valid && fb_ready`.
  - A push is accepted if the FIFO is not full, or if it is full and a pop occurs in the same cycle.
  - Otherwise the push is dropped: `fb_overflow` is set and the shadow memory still updates.
  - Push and pop in the same cycle on a non-empty FIFO leave the count unchanged.
  - Read and write pointers wrap modulo `FIFO_DEPTH`. Full and empty are distinguished by an extra pointer bit or an explicit count.
  - The FIFO never stalls the CPU; the CPU has no stall input.
- Reset:
  - Clears the keyboard register, the FIFO pointers/count and `fb_overflow`.
  - RAM and screen shadow contents are not cleared.
  - Assertion mid-stream discards all queued entries immediately.
- Reset values of outputs:
  - `fb_valid` = 0, `fb_overflow` = 0.
  - `fb_addr` and `fb_data` are don't-care while `fb_valid` = 0.
  - `inM` follows `addressM`: 0x0000 at KBD, undefined at RAM or screen locations never written.

## Timing

- Read latency is zero: `inM` is a combinational function of `addressM` and the current storage.
- Writes take effect at the rising edge.
- Read-during-write to the same address returns the old word during that cycle and the new word from the next cycle on.
- Keyboard register latency:
  - A `kbd_valid` pulse in cycle N is readable at KBD from cycle N+1.
  - A `kbd_release` pulse in cycle N clears the register from cycle N+1.
- Screen write at edge N: `fb_valid` rises after edge N if the FIFO was empty, with `fb_addr`/`fb_data` showing that entry.
- FIFO head stability:
  - The head entry holds stable while `fb_valid && !fb_ready`.
  - Ordering is strictly first in, first out.
- `fb_overflow` rises after the edge at which the drop occurs. It stays high until reset.
- Reset is asynchronous: outputs take their reset values without waiting for a clock edge. Deassertion is synchronised to `clk` by the top level.

## Test plan

- RAM readback: write 0x1234 to 0x0010, then read 0x0010 → `inM` = 0x1234. During the write cycle itself, `inM` shows the old value.
- Screen forwarding: hold `fb_ready` = 0 and write 0xAAAA to 0x4005 → the next cycle shows `fb_valid` = 1, `fb_addr` = 0x0005, `fb_data` = 0xAAAA, and reading 0x4005 gives 0xAAAA. Raise `fb_ready` for one cycle → `fb_valid` = 0.
- FIFO full and overflow: with `FIFO_DEPTH` = 16 and `fb_ready` = 0, perform 17 screen writes with data 0..16 → `fb_overflow` = 1 after the 17th. Draining yields data 0..15 in order. Reading screen location 16 still returns 16 (shadow updated).
- Full with simultaneous pop: fill the FIFO, then assert `fb_ready` during the 17th write → no overflow, and the entry is delivered last.
- Keyboard: `kbd_valid` with 0x0041 → KBD reads 0x0041 the next cycle. `kbd_valid`(0x0042) together with `kbd_release` → 0x0042. `kbd_release` alone → 0x0000. A CPU write to 0x6000 leaves the register unchanged.
- Unmapped and reset: reading 0x7000 returns 0x0000 and a write there changes nothing. Asserting `reset` asynchronously with 5 entries queued → `fb_valid` = 0, `fb_overflow` = 0 and KBD reads 0x0000 immediately, while RAM contents are preserved.

Source files
------------

// File: rtl/hack_memory_if.sv
// CPU data bus, keyboard input and screen-update stream for the Hack data memory.
// The slave modport is the memory itself; the master modport is the surrounding system.
interface hack_memory_if;
  logic [15:0] addressM;
  logic        writeM;
  logic [15:0] outM;
  logic [15:0] inM;
  logic        kbd_valid;
  logic [15:0] kbd_code;
  logic        kbd_release;
  logic        fb_valid;
  logic [12:0] fb_addr;
  logic [15:0] fb_data;
  logic        fb_ready;
  logic        fb_overflow;

  modport slave (
    input  addressM, writeM, outM, kbd_valid, kbd_code, kbd_release, fb_ready,
    output inM, fb_valid, fb_addr, fb_data, fb_overflow
  );

  modport master (
    output addressM, writeM, outM, kbd_valid, kbd_code, kbd_release, fb_ready,
    input  inM, fb_valid, fb_addr, fb_data, fb_overflow
  );
endinterface

// File: rtl/hack_memory.sv
// Hack CPU data memory: 16K RAM, 8K screen shadow, keyboard register, and a
// FIFO forwarding every screen write to the display side without stalling the CPU.
module hack_memory #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic          clk,
  input  logic          reset,
  hack_memory_if.slave  bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [15:0] ram    [0:16383];
  logic [15:0] screen [0:8191];
  logic [12:0] q_addr [0:FIFO_DEPTH-1];
  logic [15:0] q_data [0:FIFO_DEPTH-1];

  logic [15:0] kbd_reg;
  logic        ovf_reg;
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic        is_ram, is_scr, is_kbd;
  logic        full, empty, pop, push_req, push_ok;
  logic [15:0] rd_data;

  assign is_ram = (bus.addressM[15:14] == 2'b00);
  assign is_scr = (bus.addressM[15:13] == 3'b010);
  assign is_kbd = (bus.addressM == 16'h6000);

  // Extra pointer bit distinguishes full from empty.
  assign count    = wr_ptr - rd_ptr;
  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign pop      = !empty && bus.fb_ready;
  assign push_req = bus.writeM && is_scr;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push_ok  = push_req && (!full || pop);

  always_comb begin
    rd_data = 16'h0000;
    if (is_ram)      rd_data = ram[bus.addressM[13:0]];
    else if (is_scr) rd_data = screen[bus.addressM[12:0]];
    else if (is_kbd) rd_data = kbd_reg;
  end

  assign bus.inM         = rd_data;
  assign bus.fb_valid    = !empty;
  assign bus.fb_addr     = q_addr[rd_ptr[AW-1:0]];
  assign bus.fb_data     = q_data[rd_ptr[AW-1:0]];
  assign bus.fb_overflow = ovf_reg;

  // Storage is never reset; the shadow updates even when the FIFO drops the push.
  always_ff @(posedge clk) begin
    if (bus.writeM && is_ram) ram[bus.addressM[13:0]] <= bus.outM;
    if (push_req)             screen[bus.addressM[12:0]] <= bus.outM;
    if (push_ok) begin
      q_addr[wr_ptr[AW-1:0]] <= bus.addressM[12:0];
      q_data[wr_ptr[AW-1:0]] <= bus.outM;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      ovf_reg <= 1'b0;
      kbd_reg <= 16'h0000;
    end else begin
      if (push_ok)                      wr_ptr  <= wr_ptr + 1'b1;
      if (pop)                          rd_ptr  <= rd_ptr + 1'b1;
      if (push_req && !push_ok)         ovf_reg <= 1'b1;
      if (bus.kbd_valid)                kbd_reg <= bus.kbd_code;
      else if (bus.kbd_release)         kbd_reg <= 16'h0000;
    end
  end
endmodule

// File: tb/tb_hack_memory.sv
// Self-checking bench for hack_memory: directed scenarios plus randomized traffic
// compared against an array/queue reference model of the memory map.
module tb_hack_memory;
  logic clk = 1'b0;
  logic reset;
  hack_memory_if bus();

  hack_memory #(.FIFO_DEPTH(16)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int nchk = 0;
  int nfail = 0;

  logic [15:0] ram_m [0:16383];
  logic [15:0] scr_m [0:8191];
  logic [15:0] kbd_m;
  logic        ovf_m;
  logic [28:0] q_m [$];

  function automatic logic [15:0] mr(input logic [15:0] a);
    logic [15:0] off;
    off = a - 16'h4000;
    if (a < 16'h4000)       return ram_m[a[13:0]];
    else if (a < 16'h6000)  return scr_m[off[12:0]];
    else if (a == 16'h6000) return kbd_m;
    else                    return 16'h0000;
  endfunction

  task automatic drive(input logic [15:0] a, input logic we, input logic [15:0] d);
    bus.addressM = a;
    bus.writeM   = we;
    bus.outM     = d;
  endtask

  // Advance the model by one clock using the inputs as they stand before the edge.
  task automatic cycle();
    logic [15:0] off;
    if (!reset) begin
      off = bus.addressM - 16'h4000;
      if (bus.fb_ready && q_m.size() > 0) void'(q_m.pop_front());
      if (bus.writeM && bus.addressM < 16'h4000) ram_m[bus.addressM[13:0]] = bus.outM;
      if (bus.writeM && bus.addressM >= 16'h4000 && bus.addressM < 16'h6000) begin
        scr_m[off[12:0]] = bus.outM;
        if (q_m.size() < 16) q_m.push_back({off[12:0], bus.outM});
        else                 ovf_m = 1'b1;
      end
      if (bus.kbd_valid)        kbd_m = bus.kbd_code;
      else if (bus.kbd_release) kbd_m = 16'h0000;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q_m.delete();
    ovf_m = 1'b0;
    kbd_m = 16'h0000;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.kbd_valid = 0; bus.kbd_release = 0; bus.kbd_code = 0; bus.fb_ready = 0;
    drive(16'h6000, 1'b0, 16'h0);
    model_reset();
    #2;
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL rst_fb_valid act=%b exp=0", bus.fb_valid); end
    nchk++; if (bus.fb_overflow !== 1'b0) begin nfail++; $display("FAIL rst_overflow act=%b exp=0", bus.fb_overflow); end
    nchk++; if (bus.inM !== 16'h0000) begin nfail++; $display("FAIL rst_kbd act=%h exp=0000", bus.inM); end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_init();
    bus.fb_ready = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive(16'(i), 1'b1, 16'h0100 + 16'(i)); cycle();
      drive(16'h4000 + 16'(i), 1'b1, 16'h2000 + 16'(i)); cycle();
    end
    drive(16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) cycle();
    bus.fb_ready = 1'b0;
  endtask

  task automatic test_ram();
    drive(16'h0010, 1'b1, 16'h1234);
    #1;
    nchk++; if (bus.inM !== 16'h0110) begin nfail++; $display("FAIL ram_old act=%h exp=0110", bus.inM); end
    cycle();
    drive(16'h0010, 1'b0, 16'h0);
    #1;
    nchk++; if (bus.inM !== 16'h1234) begin nfail++; $display("FAIL ram_new act=%h exp=1234", bus.inM); end
  endtask

  task automatic test_screen();
    bus.fb_ready = 1'b0;
    drive(16'h4005, 1'b1, 16'hAAAA); cycle();
    drive(16'h4005, 1'b0, 16'h0); #1;
    nchk++; if (bus.fb_valid !== 1'b1) begin nfail++; $display("FAIL scr_valid act=%b exp=1", bus.fb_valid); end
    nchk++; if (bus.fb_addr !== 13'h0005) begin nfail++; $display("FAIL scr_addr act=%h exp=0005", bus.fb_addr); end
    nchk++; if (bus.fb_data !== 16'hAAAA) begin nfail++; $display("FAIL scr_data act=%h exp=AAAA", bus.fb_data); end
    nchk++; if (bus.inM !== 16'hAAAA) begin nfail++; $display("FAIL scr_read act=%h exp=AAAA", bus.inM); end
    bus.fb_ready = 1'b1; cycle(); bus.fb_ready = 1'b0; #1;
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL scr_drained act=%b exp=0", bus.fb_valid); end
  endtask

  task automatic test_overflow();
    bus.fb_ready = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(16'h4000 + 16'(i), 1'b1, 16'(i)); cycle();
    end
    drive(16'h4010, 1'b0, 16'h0); #1;
    nchk++; if (bus.fb_overflow !== 1'b1) begin nfail++; $display("FAIL ovf_set act=%b exp=1", bus.fb_overflow); end
    nchk++; if (bus.inM !== 16'h0010) begin nfail++; $display("FAIL ovf_shadow act=%h exp=0010", bus.inM); end
    bus.fb_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      nchk++;
      if (bus.fb_valid !== 1'b1 || bus.fb_data !== 16'(i) || bus.fb_addr !== 13'(i)) begin
        nfail++; $display("FAIL ovf_drain_%0d act=%b/%h/%h exp=1/%h/%h", i, bus.fb_valid, bus.fb_addr, bus.fb_data, 13'(i), 16'(i));
      end
      cycle();
    end
    bus.fb_ready = 1'b0;
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL ovf_empty act=%b exp=0", bus.fb_valid); end
    nchk++; if (bus.fb_overflow !== 1'b1) begin nfail++; $display("FAIL ovf_sticky act=%b exp=1", bus.fb_overflow); end
  endtask

  task automatic test_full_pop();
    logic [15:0] exp;
    bus.fb_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin
      drive(16'h4020 + 16'(i), 1'b1, 16'h0100 + 16'(i)); cycle();
    end
    bus.fb_ready = 1'b1;
    drive(16'h4030, 1'b1, 16'h0BEE); cycle();
    bus.fb_ready = 1'b0;
    drive(16'h0, 1'b0, 16'h0); #1;
    nchk++; if (bus.fb_overflow !== 1'b0) begin nfail++; $display("FAIL fullpop_ovf act=%b exp=0", bus.fb_overflow); end
    bus.fb_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      exp = (i == 16) ? 16'h0BEE : 16'h0100 + 16'(i);
      nchk++;
      if (bus.fb_valid !== 1'b1 || bus.fb_data !== exp) begin
        nfail++; $display("FAIL fullpop_drain_%0d act=%b/%h exp=1/%h", i, bus.fb_valid, bus.fb_data, exp);
      end
      cycle();
    end
    bus.fb_ready = 1'b0;
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL fullpop_empty act=%b exp=0", bus.fb_valid); end
  endtask

  task automatic test_kbd();
    drive(16'h6000, 1'b0, 16'h0);
    bus.kbd_valid = 1'b1; bus.kbd_code = 16'h0041; cycle();
    bus.kbd_valid = 1'b0; #1;
    nchk++; if (bus.inM !== 16'h0041) begin nfail++; $display("FAIL kbd_load act=%h exp=0041", bus.inM); end
    bus.kbd_valid = 1'b1; bus.kbd_release = 1'b1; bus.kbd_code = 16'h0042; cycle();
    bus.kbd_valid = 1'b0; bus.kbd_release = 1'b0; #1;
    nchk++; if (bus.inM !== 16'h0042) begin nfail++; $display("FAIL kbd_both act=%h exp=0042", bus.inM); end
    bus.kbd_release = 1'b1; cycle(); bus.kbd_release = 1'b0; #1;
    nchk++; if (bus.inM !== 16'h0000) begin nfail++; $display("FAIL kbd_release act=%h exp=0000", bus.inM); end
    bus.kbd_valid = 1'b1; bus.kbd_code = 16'h0055; cycle(); bus.kbd_valid = 1'b0;
    drive(16'h6000, 1'b1, 16'h9999); cycle();
    drive(16'h6000, 1'b0, 16'h0); #1;
    nchk++; if (bus.inM !== 16'h0055) begin nfail++; $display("FAIL kbd_cpu_write act=%h exp=0055", bus.inM); end
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL kbd_no_push act=%b exp=0", bus.fb_valid); end
  endtask

  task automatic test_unmapped();
    drive(16'h7000, 1'b0, 16'h0); #1;
    nchk++; if (bus.inM !== 16'h0000) begin nfail++; $display("FAIL unm_read act=%h exp=0000", bus.inM); end
    drive(16'h7000, 1'b1, 16'hFFFF); cycle();
    drive(16'h7000, 1'b0, 16'h0); #1;
    nchk++; if (bus.inM !== 16'h0000) begin nfail++; $display("FAIL unm_readback act=%h exp=0000", bus.inM); end
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL unm_no_push act=%b exp=0", bus.fb_valid); end
    drive(16'h0010, 1'b0, 16'h0); #1;
    nchk++; if (bus.inM !== 16'h1234) begin nfail++; $display("FAIL unm_ram_intact act=%h exp=1234", bus.inM); end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] exp;
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: a = 16'($urandom_range(0, 63));
        3, 4, 5: a = 16'h4000 + 16'($urandom_range(0, 63));
        6:       a = 16'h6000;
        default: case ($urandom_range(0, 3))
                   0: a = 16'h6001;
                   1: a = 16'h7000;
                   2: a = 16'h8000;
                   default: a = 16'hFFFF;
                 endcase
      endcase
      drive(a, ($urandom_range(0, 9) < 4), 16'($urandom));
      bus.fb_ready    = ($urandom_range(0, 2) == 0);
      bus.kbd_valid   = ($urandom_range(0, 9) == 0);
      bus.kbd_release = ($urandom_range(0, 9) == 0);
      bus.kbd_code    = 16'($urandom);
      #1;
      exp = mr(a);
      nchk++; if (bus.inM !== exp) begin nfail++; $display("FAIL rnd_inM addr=%h act=%h exp=%h", a, bus.inM, exp); end
      nchk++; if (bus.fb_valid !== (q_m.size() != 0)) begin nfail++; $display("FAIL rnd_valid act=%b exp=%b", bus.fb_valid, q_m.size() != 0); end
      if (q_m.size() != 0) begin
        nchk++;
        if ({bus.fb_addr, bus.fb_data} !== q_m[0]) begin
          nfail++; $display("FAIL rnd_head act=%h/%h exp=%h/%h", bus.fb_addr, bus.fb_data, q_m[0][28:16], q_m[0][15:0]);
        end
      end
      nchk++; if (bus.fb_overflow !== ovf_m) begin nfail++; $display("FAIL rnd_ovf act=%b exp=%b", bus.fb_overflow, ovf_m); end
      cycle();
    end
    drive(16'h0, 1'b0, 16'h0);
    bus.fb_ready = 1'b0; bus.kbd_valid = 1'b0; bus.kbd_release = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    cycle();
    bus.kbd_valid = 1'b1; bus.kbd_code = 16'h0077; cycle(); bus.kbd_valid = 1'b0;
    bus.fb_ready = 1'b0;
    drive(16'h0010, 1'b1, 16'h4321); cycle();
    for (int i = 0; i < 5; i++) begin
      drive(16'h4000 + 16'(i), 1'b1, 16'h0C00 + 16'(i)); cycle();
    end
    drive(16'h6000, 1'b0, 16'h0); #1;
    nchk++; if (bus.fb_valid !== 1'b1 || bus.inM !== 16'h0077) begin nfail++; $display("FAIL areset_pre act=%b/%h exp=1/0077", bus.fb_valid, bus.inM); end
    #1;
    reset = 1'b1;
    model_reset();
    #1;
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL areset_valid act=%b exp=0", bus.fb_valid); end
    nchk++; if (bus.fb_overflow !== 1'b0) begin nfail++; $display("FAIL areset_ovf act=%b exp=0", bus.fb_overflow); end
    nchk++; if (bus.inM !== 16'h0000) begin nfail++; $display("FAIL areset_kbd act=%h exp=0000", bus.inM); end
    drive(16'h0010, 1'b0, 16'h0); #1;
    nchk++; if (bus.inM !== 16'h4321) begin nfail++; $display("FAIL areset_ram act=%h exp=4321", bus.inM); end
    reset = 1'b0;
    cycle();
    nchk++; if (bus.fb_valid !== 1'b0) begin nfail++; $display("FAIL areset_after act=%b exp=0", bus.fb_valid); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_ram();
    test_screen();
    test_overflow();
    do_reset();
    test_full_pop();
    test_kbd();
    test_unmapped();
    do_reset();
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
